// File: rtl/lisa_rx_sched.sv
// ---------------------------------------------------------------------------
// lisa_rx_sched
//
// Front end shared by a lisa_rx8n serial receiver and two byte consumers.
//   * Baud generator: square wave on baud_ref, toggling every (div+1) clocks,
//     used by the receiver as its 16x oversampling reference.
//   * Drain FSM (IDLE -> PULSE -> WAIT): takes one byte per data_avail episode
//     from the receiver with a single-cycle rx_rd pulse and pushes it into a
//     small FIFO.
//   * Registered arbiter: hands FIFO bytes to consumer 0 (CPU) or 1 (debug)
//     with a one-cycle one-hot gnt pulse; rdata holds until the next grant.
//
// Ports
//   clk       in   1               system clock
//   rst       in   1               asynchronous, active-high reset
//   div       in   DIV_W           baud_ref half-period minus 1, in clocks
//   baud_ref  out  1               baud reference to lisa_rx8n
//   rx_d      in   8               receiver data
//   rx_avail  in   1               receiver data_avail
//   rx_rd     out  1               receiver read strobe (one-cycle pulse)
//   req       in   2               level request per consumer
//   gnt       out  2               one-hot grant pulse
//   rdata     out  8               byte delivered with gnt
//   count     out  clog2(DEPTH)+1  FIFO occupancy
//
// Configuration
//   LISA_RX_SCHED_PRIO_EN  defined:   fixed priority, consumer 0 wins a contest.
//                          undefined: round-robin between the two consumers.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module lisa_rx_sched #(
    parameter int DEPTH = 4,
    parameter int DIV_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DIV_W-1:0]         div,
    output logic                     baud_ref,
    input  logic [7:0]               rx_d,
    input  logic                     rx_avail,
    output logic                     rx_rd,
    input  logic [1:0]               req,
    output logic [1:0]               gnt,
    output logic [7:0]               rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    // -----------------------------------------------------------------------
    // Baud generator
    // -----------------------------------------------------------------------
    logic [DIV_W-1:0] cnt;

    // NOTE: sequential state is always written with non-blocking assignments
    // so every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            baud_ref <= 1'b0;
        end else if (cnt >= div) begin
            // ">=" rather than "==" so a divisor lowered below the running
            // count reloads on the next clock instead of wrapping the counter.
            cnt      <= '0;
            baud_ref <= ~baud_ref;
        end else begin
            cnt      <= cnt + 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // FIFO status
    // -----------------------------------------------------------------------
    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;

    // Extra wrap bit: equal indices with differing MSBs means full.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign count = wr_ptr - rd_ptr;

    // -----------------------------------------------------------------------
    // Drain FSM
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        WAIT
    } state_t;

    state_t state;
    state_t state_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_next = state;
        push       = 1'b0;
        case (state)
            IDLE: begin
                // Pre-edge full flag: a pop in this same cycle does not make
                // room for the push until the following cycle.
                if (rx_avail && !full) begin
                    push       = 1'b1;
                    state_next = PULSE;
                end
            end
            PULSE: begin
                state_next = WAIT;
            end
            WAIT: begin
                // The receiver keeps data_avail high until it has seen rd;
                // waiting for it to drop prevents pushing the same byte twice.
                if (!rx_avail) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // rx_rd is high exactly during the cycle after a push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_rd <= 1'b0;
        end else begin
            rx_rd <= push;
        end
    end

    // -----------------------------------------------------------------------
    // FIFO storage and pointers
    // -----------------------------------------------------------------------
    // NOTE: the data array has no reset; the pointers alone define which
    // entries are valid, so clearing the storage would buy nothing.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= rx_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Arbiter
    // -----------------------------------------------------------------------
    logic win;   // winning consumer index for this cycle

`ifdef LISA_RX_SCHED_PRIO_EN
    always_comb begin
        pop = !empty && (|req);
        // Consumer 0 wins whenever it requests.
        win = !req[0];
    end
`else
    logic last;  // consumer granted most recently

    always_comb begin
        pop = !empty && (|req);
        win = !req[0];
        if (req == 2'b11) begin
            win = ~last;
        end
    end

    // Reset to consumer 1 so consumer 0 wins the first contested grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= 1'b1;
        end else if (pop) begin
            last <= win;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt   <= 2'b00;
            rdata <= 8'h00;
        end else if (pop) begin
            gnt   <= win ? 2'b10 : 2'b01;
            rdata <= mem[rd_ptr[AW-1:0]];
        end else begin
            gnt   <= 2'b00;
        end
    end

endmodule
